// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, round constants,
// word helpers and the S-box table also used by the round datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      MIX  = 2'd2
   } ks_state_t;

   localparam int         AES_NUM_ROUNDS = 10;
   localparam logic [7:0] RCON_INIT      = 8'h01;
   localparam logic [7:0] RCON_POLY      = 8'h1B;

   // Multiply by x in GF(2^8); also steps rcon to its next value.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expander.sv
// On-the-fly AES-128 round-key generator. Byte-serial SubWord by default;
// define AES_KS_PARALLEL_SBOX_EN for four S-boxes and single-cycle advance.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic         ks_advance,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         ks_busy,
   output logic         ks_done,
   output logic         ks_last,
   output logic         ks_err
);

   ks_state_t    state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   num_q, num_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [31:0]  w_q, w_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   logic [4:0]   sel_lsb_s;
   logic [7:0]   sub_byte_s;
   logic [31:0]  sub_word_s;
   logic [31:0]  nk0_s, nk1_s, nk2_s, nk3_s;

   // Byte i of w sits at bits [8*(3-i) +: 8], so the MSB byte is handled first.
   assign sel_lsb_s = {~cnt_q, 3'b000};

`ifdef AES_KS_PARALLEL_SBOX_EN
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (w_q[8*g +: 8]),
         .out_o (sub_word_s[8*g +: 8])
      );
   end
   assign sub_byte_s = sub_word_s[sel_lsb_s +: 8];
`else
   aes_sbox u_sbox (
      .in_i  (w_q[sel_lsb_s +: 8]),
      .out_o (sub_byte_s)
   );
   // w has been substituted in place during SUB.
   assign sub_word_s = w_q;
`endif

   assign nk0_s = key_q[127:96] ^ sub_word_s ^ {rcon_q, 24'h000000};
   assign nk1_s = key_q[95:64] ^ nk0_s;
   assign nk2_s = key_q[63:32] ^ nk1_s;
   assign nk3_s = key_q[31:0] ^ nk2_s;

   // Next-state and datapath selection; a load overrides everything.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      num_d   = num_q;
      rcon_d  = rcon_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (key_load) begin
         key_d   = key_in;
         num_d   = 4'd0;
         rcon_d  = RCON_INIT;
         cnt_d   = 2'd0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (ks_advance) begin
                  if (num_q == 4'(NUM_ROUNDS)) begin
                     err_d = 1'b1;
                  end else begin
                     w_d   = rot_word(key_q[31:0]);
                     cnt_d = 2'd0;
`ifdef AES_KS_PARALLEL_SBOX_EN
                     state_d = MIX;
`else
                     state_d = SUB;
`endif
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            SUB: begin
               err_d                 = ks_advance;
               w_d[sel_lsb_s +: 8]   = sub_byte_s;
               cnt_d                 = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = MIX;
               end else begin
                  state_d = SUB;
               end
            end
            MIX: begin
               err_d   = ks_advance;
               key_d   = {nk0_s, nk1_s, nk2_s, nk3_s};
               num_d   = num_q + 4'd1;
               rcon_d  = xtime(rcon_q);
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= 128'd0;
         num_q   <= 4'd0;
         rcon_q  <= RCON_INIT;
         w_q     <= 32'd0;
         cnt_q   <= 2'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         num_q   <= num_d;
         rcon_q  <= rcon_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign round_key = key_q;
   assign round_num = num_q;
   assign ks_busy   = (state_q != IDLE);
   assign ks_done   = done_q;
   assign ks_err    = err_q;
   assign ks_last   = (num_q == 4'(NUM_ROUNDS));

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- On-the-fly AES-128 round-key generator for the fine multicycle core; sits beside the round controller and consumes its key-schedule enable.
- Loads the 128-bit cipher key, which is round key 0, then produces one round key per advance request, up to round key 10.
- A byte-serial SubWord, using one shared S-box over 4 cycles, keeps area low.
- Round key, round number and done/busy flags feed the AddRoundKey datapath.

Parameters:
NUM_ROUNDS, 10, index of the final round key; fixed at 10 for AES-128, not meant to be overridden.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
key_load  in  1  sample key_in as round key 0
key_in  in  128  cipher key, FIPS-197 byte order (byte 0 = [127:120])
ks_advance  in  1  request next round key (driven by controller enable_ks)
round_key  out  128  current round key
round_num  out  4  index of round_key, 0..10
ks_busy  out  1  expansion in progress
ks_done  out  1  one-cycle pulse when new round_key is valid
ks_last  out  1  round_num == NUM_ROUNDS
ks_err  out  1  one-cycle pulse when ks_advance is rejected

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: round_key=0, round_num=0, rcon=8'h01, state=IDLE, ks_busy=0, ks_done=0, ks_last=0, ks_err=0, byte counter=0.
- States: IDLE, SUB, MIX.
- IDLE + key_load:
  - round_key<=key_in, round_num<=0, rcon<=8'h01; stay IDLE.
  - No ks_done for a load.
- IDLE + ks_advance with round_num<10:
  - Capture temp word w = RotWord(round_key[31:0]); go to SUB; ks_busy=1 from the next cycle.
- SUB: cycles 0..3 substitute byte i of w through the S-box, MSB byte first; after byte 3 go to MIX.
- MIX, single cycle:
  - w0'=w0^SubRot^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - round_key<=new key; round_num<=round_num+1.
  - rcon<=xtime(rcon), i.e. 8'h80 -> 8'h1B.
  - ks_done pulses the same cycle the new key is registered; return to IDLE.
- Latency: ks_advance accepted at edge N; new round_key and ks_done visible after edge N+5. ks_busy is high for 5 cycles.
- Rejected advances (round_key unchanged, ks_err pulses 1 cycle later):
  - ks_advance while ks_busy.
  - ks_advance when round_num==10.
- key_load while busy: abort expansion, load key_in, round_num=0, rcon=01, state IDLE, ks_busy=0 next cycle, no ks_done.
- key_load and ks_advance in the same cycle: load wins; advance dropped silently, no ks_err.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- rcon is not used after round 10.
- ks_last is combinational from round_num.
- rst mid-operation: all state returns to reset values immediately; no pending pulses.

Optional Feature:
AES_KS_PARALLEL_SBOX_EN:
- Defined:
  - Four S-box instances; SUB is skipped and IDLE goes directly to MIX.
  - Advance latency is 1 cycle: new key and ks_done after edge N+1; ks_busy high 1 cycle.
  - All reject rules are unchanged.
- Undefined: byte-serial single S-box, 5-cycle latency as above.

Decomposition:
- Shared package aes_pkg:
  - ks_state_t enum (IDLE, SUB, MIX).
  - AES_NUM_ROUNDS=10, RCON_INIT=8'h01, RCON_POLY=8'h1B.
  - Functions xtime() and rot_word().
  - S-box constant table, shared with the round datapath.
- Sub-module aes_sbox: 8-bit combinational S-box lookup, instanced once, or 4 times with the macro.

Test Plan:
- Load key 2b7e151628aed2a6abf7158809cf4f3c -> round_key equals key, round_num=0, ks_done stays 0.
- Advance once -> after 5 cycles (1 with the macro) round_key=a0fafe1788542cb123a339392a6c7605, round_num=1, ks_done high for exactly 1 cycle.
- Advance 10 times, each after ks_done -> final round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, round_num=10, ks_last=1. An 11th advance -> ks_err pulse, key unchanged.
- Advance, then assert ks_advance again 2 cycles later while ks_busy -> ks_err pulse; exactly one ks_done; round_num=1.
- Advance, then key_load with key 000102030405060708090a0b0c0d0e0f at busy cycle 3 -> no ks_done, round_num=0, round_key=000102…0f. Next advance gives d6aa74fdd2af72fadaa678f1d6ab76fe.
- Assert rst during SUB -> all outputs 0 immediately. A fresh load+advance after release gives the correct round 1 key.
